// File: rtl/apb_pkg.sv
// Purpose: shared types and response encodings for the APB completer register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

  // Completer bus-phase tracker.
  //   IDLE   : no transfer in flight; watching for a setup phase.
  //   SETUP  : a setup phase was seen last cycle; this cycle is the first access cycle.
  //   ACCESS : second or later access cycle (wait states being inserted).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic APB_OKAY = 1'b0;
  localparam logic APB_ERR  = 1'b1;

endpackage

// File: rtl/apb_regfile.sv
// Purpose: DEPTH x DATA_W register array, one synchronous write port, one async read port.
// Latency: write lands on the clock edge that samples we; read is combinational.
// Backpressure: none; accepts a write every cycle.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-low clear of every register
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index
//   rdata  out  mem[raddr], combinational
module apb_regfile #(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 32,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_completer_regfile.sv
// Purpose: APB completer servicing transfers against a local word-addressed register file.
// Latency: pready on access cycle WAIT_CYCLES+1; read data combinational in that cycle.
// Backpressure: stretches the access phase with WAIT_CYCLES wait states via pready=0.
//
// Ports:
//   clk      in   clock, all state on the rising edge
//   reset    in   synchronous reset, active low; also forces pready/pslverr/prdata to 0
//   psel     in   completer select
//   penable  in   access phase indicator
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address (ADDR_W)
//   pwdata   in   write data (DATA_W)
//   prdata   out  read data, nonzero only in an error-free read pready cycle
//   pready   out  transfer completes this cycle
//   pslverr  out  error response, only asserted together with pready
module apb_completer_regfile
  import apb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 16,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(4 * DEPTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;

  // ---------------------------------------------------------------------------
  // Address decode. The subtraction carries one extra bit so that an address
  // below BASE_ADDR shows up as a borrow instead of wrapping into range.
  // ---------------------------------------------------------------------------
  logic [ADDR_W:0]   addr_diff;
  logic [ADDR_W-1:0] addr_off;
  logic              addr_bad;
  logic [IDX_W-1:0]  idx;

  always_comb begin
    addr_diff = {1'b0, paddr} - {1'b0, BASE_ADDR};
    addr_off  = addr_diff[ADDR_W-1:0];
    addr_bad  = addr_diff[ADDR_W] | (addr_off >= SPAN) | (paddr[1:0] != 2'b00);
    idx       = addr_off[2 +: IDX_W];
  end

  // ---------------------------------------------------------------------------
  // Phase tracking. A setup phase can only be recognised in the cycle it is
  // driven, so the register reads SETUP during the first access cycle and
  // ACCESS during any later one; both count as access cycles. After the pready
  // cycle the FSM returns to IDLE, which is exactly where a back-to-back setup
  // phase in the very next cycle is picked up, so no dead cycle is inserted.
  // ---------------------------------------------------------------------------
  logic in_access;
  logic cnt_done;
  logic pready_raw;

  assign in_access  = psel & penable & ((state_q == SETUP) | (state_q == ACCESS));
  assign cnt_done   = (wait_cnt_q == '0);
  assign pready_raw = in_access & cnt_done;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        // psel & penable without a preceding setup is a protocol violation and
        // is deliberately ignored here.
        if (psel && !penable) begin
          state_d    = SETUP;
          wait_cnt_d = WAIT_LOAD;
          err_d      = addr_bad ? APB_ERR : APB_OKAY;
        end
      end
      SETUP, ACCESS: begin
        if (psel && penable) begin
          if (cnt_done) begin
            state_d = IDLE;
          end else begin
            state_d    = ACCESS;
            wait_cnt_d = wait_cnt_q - 1'b1;
          end
        end else begin
          // Requester abandoned the transfer: no write, no response.
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      err_q      <= APB_OKAY;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file and response.
  // ---------------------------------------------------------------------------
  logic              rf_we;
  logic [DATA_W-1:0] rf_rdata;

  assign rf_we = pready & pwrite & (err_q == APB_OKAY);

  apb_regfile #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .waddr (idx),
    .wdata (pwdata),
    .raddr (idx),
    .rdata (rf_rdata)
  );

  always_comb begin
    pready  = reset & pready_raw;
    pslverr = pready & (err_q == APB_ERR);
    prdata  = '0;
    if (pready && !pwrite && (err_q == APB_OKAY)) begin
      prdata = rf_rdata;
    end
  end

endmodule
